// File: rtl/mem_access_unit.sv
// Load/store unit: byte-lane alignment and extension, local data memory below DM_LIMIT,
// and a stalling request/ack IO port with a cycle-count timeout above it.
module mem_access_unit #(
    parameter int unsigned DM_AW      = 12,
    parameter logic [15:0] DM_LIMIT   = 16'h3000,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        io_req,
    output logic        io_we,
    output logic [29:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_be,
    input  logic        io_ack,
    input  logic [31:0] io_rdata
);

    localparam int unsigned DM_WORDS = 1 << DM_AW;
    localparam int unsigned CW       = $clog2(IO_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   raw_q;
    logic [1:0]    lo_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          bus_err_q;

    logic [31:0]   dm [DM_WORDS];

    logic          valid;
    logic          is_dm;
    logic          accept;
    logic          dm_acc;
    logic          io_acc;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   shifted;
    logic [DM_AW-1:0] dm_idx;

    // Request decode: alignment, byte enables, address region
    always_comb begin
        valid    = mem_read | mem_write;
        misalign = valid & (((size == 2'b01) & addr[0]) |
                            (size[1] & (addr[1:0] != 2'b00)));
        case (size)
            2'b00:   be = 4'(4'b0001 << addr[1:0]);
            2'b01:   be = 4'(4'b0011 << {addr[1], 1'b0});
            default: be = 4'hF;
        endcase
        wlane  = wdata << {addr[1:0], 3'b000};
        is_dm  = addr[15:0] < DM_LIMIT;
        accept = (state_q == IDLE) & valid & ~flush & ~misalign;
        dm_acc = accept & is_dm;
        io_acc = accept & ~is_dm;
        dm_idx = addr[DM_AW+1:2];
    end

    // IO port and stall; the pipeline holds addr/wdata stable while stalled
    always_comb begin
        io_req   = (state_q == REQ);
        io_we    = io_req & mem_write;
        io_be    = io_req ? be : 4'h0;
        io_addr  = addr[31:2];
        io_wdata = wlane;
        stall    = io_req | io_acc;
        bus_err  = bus_err_q;
    end

    // Load result extraction from the registered word and access attributes
    always_comb begin
        shifted = raw_q >> {lo_q, 3'b000};
        case (size_q)
            2'b00:   rdata = uns_q ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   rdata = uns_q ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata = raw_q;
        endcase
    end

    // Access FSM, timeout counter and load data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            raw_q     <= '0;
            lo_q      <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && mem_read) begin
                        lo_q   <= addr[1:0];
                        size_q <= size;
                        uns_q  <= load_unsigned;
                    end
                    if (dm_acc && mem_read) raw_q <= dm[dm_idx];
                    if (io_acc) state_q <= REQ;
                end
                REQ: begin
                    if (io_ack) begin
                        raw_q   <= io_rdata;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else if (cnt_q == CW'(IO_TIMEOUT - 1)) begin
                        raw_q     <= '0;
                        cnt_q     <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data memory byte-masked write; contents survive reset
    always_ff @(posedge clk) begin
        if (dm_acc && mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) dm[dm_idx][b*8 +: 8] <= wlane[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: DM load/store alignment, misalign, flush,
// IO handshake, timeout and reset behaviour against hand-computed values.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        io_req;
    logic        io_we;
    logic [29:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_be;
    logic        io_ack;
    logic [31:0] io_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .size         (size),
        .load_unsigned(load_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .io_req       (io_req),
        .io_we        (io_we),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_be        (io_be),
        .io_ack       (io_ack),
        .io_rdata     (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        flush     = 1'b0;
        io_ack    = 1'b0;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
        mem_read      = rd;
        mem_write     = wr;
        size          = sz;
        load_unsigned = uns;
        addr          = a;
        wdata         = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        idle_in();
        size = 2'b10; load_unsigned = 1'b0; addr = '0; wdata = '0; io_rdata = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_rdata",   rdata,           32'h0);
        chk("rst_stall",   32'(stall),      32'h0);
        chk("rst_bus_err", 32'(bus_err),    32'h0);
        chk("rst_io_req",  32'(io_req),     32'h0);
        chk("rst_io_we",   32'(io_we),      32'h0);
        chk("rst_io_be",   32'(io_be),      32'h0);

        // DM word store then load
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        #1;
        chk("dm_st_stall", 32'(stall),    32'h0);
        chk("dm_st_mis",   32'(misalign), 32'h0);
        step();
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        step();
        chk("ld_word", rdata, 32'hDEADBEEF);

        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        step();
        chk("ld_b103_s", rdata, 32'hFFFFFFDE);
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        step();
        chk("ld_b103_u", rdata, 32'h000000DE);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        step();
        chk("ld_h102_s", rdata, 32'hFFFFDEAD);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
        step();
        chk("ld_h100_u", rdata, 32'h0000BEEF);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        step();
        chk("ld_b100_s", rdata, 32'hFFFFFFEF);

        // Misaligned accesses
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h101, 32'h1234);
        #1;
        chk("mis_h101",     32'(misalign), 32'h1);
        chk("mis_h101_stl", 32'(stall),    32'h0);
        step();
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        #1;
        chk("mis_w102", 32'(misalign), 32'h1);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        #1;
        chk("mis_h102", 32'(misalign), 32'h0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        step();
        chk("mis_unchanged", rdata, 32'hDEADBEEF);

        // Flushed byte store must not commit
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h55);
        flush = 1'b1;
        step();
        flush = 1'b0;
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        step();
        chk("flush_unchanged", rdata, 32'hDEADBEEF);

        // Byte store followed immediately by load of the same word
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h55);
        step();
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        step();
        chk("st_ld_fwd", rdata, 32'hDE55BEEF);

        // IO word store, ack in third REQ cycle
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h7F00, 32'hCAFEF00D);
        #1;
        chk("io_idle_stall", 32'(stall),  32'h1);
        chk("io_idle_req",   32'(io_req), 32'h0);
        step();
        chk("io_req1",    32'(io_req),   32'h1);
        chk("io_we1",     32'(io_we),    32'h1);
        chk("io_be1",     32'(io_be),    32'hF);
        chk("io_addr1",   32'(io_addr),  32'h1FC0);
        chk("io_wdata1",  io_wdata,      32'hCAFEF00D);
        chk("io_stall1",  32'(stall),    32'h1);
        step();
        chk("io_stall2",  32'(stall),    32'h1);
        step();
        io_ack = 1'b1;
        #1;
        chk("io_stall3",  32'(stall),    32'h1);
        step();
        idle_in();
        #1;
        chk("done_stall", 32'(stall),    32'h0);
        chk("done_req",   32'(io_req),   32'h0);
        chk("done_berr",  32'(bus_err),  32'h0);
        step();

        // IO byte store lane placement
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h7F01, 32'hA5);
        step();
        chk("io_b_be",    32'(io_be), 32'h2);
        chk("io_b_wdata", io_wdata,   32'h0000A500);
        io_ack = 1'b1;
        step();
        idle_in();
        step();

        // Stray ack while idle has no effect
        io_ack = 1'b1;
        #1;
        chk("ack_idle_stall", 32'(stall), 32'h0);
        step();
        chk("ack_idle_req", 32'(io_req), 32'h0);
        io_ack = 1'b0;

        // IO load timeout
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
        step();
        n = 0;
        while (io_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        idle_in();
        #1;
        chk("to_cycles", 32'(n),       32'd15);
        chk("to_berr",   32'(bus_err), 32'h1);
        chk("to_rdata",  rdata,        32'h0);
        chk("to_stall",  32'(stall),   32'h0);
        step();
        chk("to_berr_clr", 32'(bus_err), 32'h0);

        // IO half load with data
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h8002, 32'h0);
        io_rdata = 32'h9ABC1234;
        step();
        io_ack = 1'b1;
        step();
        idle_in();
        #1;
        chk("io_ld_half", rdata, 32'hFFFF9ABC);
        step();

        // Flushed IO access is never issued
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h5000, 32'h0);
        flush = 1'b1;
        #1;
        chk("io_flush_stall", 32'(stall), 32'h0);
        step();
        chk("io_flush_req", 32'(io_req), 32'h0);
        idle_in();

        // Reset during REQ
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h5000, 32'h0);
        step();
        chk("rq_req", 32'(io_req), 32'h1);
        rst = 1'b1;
        idle_in();
        step();
        chk("rq_rst_req",  32'(io_req),  32'h0);
        chk("rq_rst_berr", 32'(bus_err), 32'h0);
        rst = 1'b0;
        step();
        chk("rq_after_req",   32'(io_req),  32'h0);
        chk("rq_after_berr",  32'(bus_err), 32'h0);
        chk("rq_after_stall", 32'(stall),   32'h0);

        // DM survives reset
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        step();
        idle_in();
        chk("dm_keep", rdata, 32'hDE55BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
